pwm_peripheral: RTL and testbench

- Consumes the five 8-bit control registers written over SPI: output enables, PWM-mode enables and duty cycle.
- Drives 16 registered output pins. Each pin is statically low, statically high, or PWM-modulated.
- PWM frequency is about 3 kHz from a 10 MHz clk: a clock prescaler feeds an 8-bit period counter.
- Duty-cycle changes are shadowed, so they take effect only at a period boundary and never cause glitches.

---
 rtl/pwm_pkg.sv | 19 +
 rtl/pwm_timebase.sv | 43 ++++
 rtl/pwm_peripheral.sv | 55 +++++
 tb/tb_pwm_peripheral.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared constants and the PWM compare used by the pwm_peripheral slice.
package pwm_pkg;

    localparam int PWM_BITS        = 8;
    localparam int CLK_DIV_DEFAULT = 13;
    localparam int NUM_PINS        = 16;

    localparam logic [PWM_BITS-1:0] DUTY_FULL = 8'hFF;
    localparam logic [PWM_BITS-1:0] DUTY_OFF  = 8'h00;

    // 0xFF is treated as a true 100% so the pin never drops for the cnt==255 slot.
    function automatic logic pwm_level(input logic [PWM_BITS-1:0] cnt,
                                       input logic [PWM_BITS-1:0] duty);
        if (duty == DUTY_FULL) return 1'b1;
        if (duty == DUTY_OFF)  return 1'b0;
        return (cnt < duty);
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Prescaler, free-running period counter and period-boundary duty shadow.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PWM_BITS-1:0] duty_req,
    output logic [PWM_BITS-1:0] pwm_cnt,
    output logic [PWM_BITS-1:0] duty_shadow,
    output logic                period_start
);

    localparam int                  PRE_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(CLK_DIV - 1);
    localparam logic [PWM_BITS-1:0] CNT_MAX  = '1;

    logic [PRE_W-1:0] prescale;
    logic             tick;
    logic             wrap;

    assign tick = (prescale == PRE_LAST);
    assign wrap = tick && (pwm_cnt == CNT_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescale     <= '0;
            pwm_cnt      <= '0;
            duty_shadow  <= DUTY_OFF;
            period_start <= 1'b0;
        end else begin
            prescale     <= tick ? '0 : prescale + PRE_W'(1);
            period_start <= wrap;
            if (tick)
                pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            // Capture on the wrap tick itself so a write on that cycle is the one taken.
            if (wrap)
                duty_shadow <= duty_req;
        end
    end

endmodule

// File: rtl/pwm_peripheral.sv
// Sixteen registered pins, each forced low, forced high or driven by the shared PWM level.
module pwm_peripheral
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          en_reg_out_7_0,
    input  logic [7:0]          en_reg_out_15_8,
    input  logic [7:0]          en_reg_pwm_7_0,
    input  logic [7:0]          en_reg_pwm_15_8,
    input  logic [PWM_BITS-1:0] pwm_duty_cycle,
    output logic [NUM_PINS-1:0] out,
    output logic                period_start
);

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] duty_shadow;
    logic [NUM_PINS-1:0] en_out;
    logic [NUM_PINS-1:0] en_pwm;
    logic                level;
    logic [NUM_PINS-1:0] pin_next;

    pwm_timebase #(
        .CLK_DIV (CLK_DIV)
    ) u_timebase (
        .clk          (clk),
        .rst          (rst),
        .duty_req     (pwm_duty_cycle),
        .pwm_cnt      (pwm_cnt),
        .duty_shadow  (duty_shadow),
        .period_start (period_start)
    );

    assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    assign level  = pwm_level(pwm_cnt, duty_shadow);

    always_comb begin
        pin_next = '0;
        for (int i = 0; i < NUM_PINS; i++) begin
            if (en_out[i])
                pin_next[i] = en_pwm[i] ? level : 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            out <= '0;
        else
            out <= pin_next;
    end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Scoreboard bench for pwm_peripheral: expected period measurements are queued, then popped and checked.
module tb_pwm_peripheral;

    localparam int PERIOD = 3328;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8;
    logic [7:0]  pwm_duty_cycle;
    logic [15:0] out;
    logic        period_start;

    pwm_peripheral dut (
        .clk             (clk),
        .rst             (rst),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .out             (out),
        .period_start    (period_start)
    );

    always #50 clk = ~clk;

    typedef struct {
        string tag;
        int    val;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic sb_push(input string tag, input int val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic sb_check(input int obs);
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_underflow", 1, 0);
        end else begin
            e = sb.pop_front();
            chk(e.tag, obs, e.val);
        end
    endtask

    task automatic set_en(input logic [15:0] eo, input logic [15:0] ep);
        {en_reg_out_15_8, en_reg_out_7_0} = eo;
        {en_reg_pwm_15_8, en_reg_pwm_7_0} = ep;
    endtask

    // Leaves the bench at the negedge on which period_start is seen.
    task automatic wait_ps();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_start && n < PERIOD + 100);
        if (!period_start)
            chk("period_start_timeout", 0, 1);
    endtask

    // Starts at a period_start negedge; samples the 3328 cycles of the following period,
    // ending on the next period_start. Optionally writes a new duty mid-period.
    task automatic measure(input logic [15:0] pat, input int chg_at, input logic [7:0] chg_duty,
                           output int hi, output int lo, output int fall, output int sp);
        logic prev_hi;
        hi = 0; lo = 0; fall = 0; sp = 0;
        prev_hi = 1'b0;
        for (int i = 1; i <= PERIOD; i++) begin
            if (i == chg_at)
                pwm_duty_cycle = chg_duty;
            @(negedge clk);
            if (out == pat)
                hi++;
            else if (out == 16'h0000)
                lo++;
            if (fall == 0 && prev_hi && out != pat)
                fall = i;
            prev_hi = (out == pat);
            if (period_start && sp == 0)
                sp = i;
        end
    endtask

    task automatic run_measure(input string name, input logic [15:0] pat,
                               input int chg_at, input logic [7:0] chg_duty,
                               input int exp_hi, input int exp_lo, input int exp_fall);
        int hi, lo, fall, sp;
        sb_push({name, "_high"}, exp_hi);
        sb_push({name, "_low"}, exp_lo);
        sb_push({name, "_fall"}, exp_fall);
        sb_push({name, "_spacing"}, PERIOD);
        measure(pat, chg_at, chg_duty, hi, lo, fall, sp);
        sb_check(hi);
        sb_check(lo);
        sb_check(fall);
        sb_check(sp);
    endtask

    initial begin
        int n, nonzero;

        rst = 1'b1;
        set_en(16'h0000, 16'h0000);
        pwm_duty_cycle = 8'h00;
        repeat (3) @(negedge clk);
        sb_push("reset_out", 0);
        sb_push("reset_period_start", 0);
        sb_check(int'(out));
        sb_check(int'(period_start));
        rst = 1'b0;

        // Static-high pins 7..0, one clk after the write.
        set_en(16'h00FF, 16'h0000);
        sb_push("static_out", 16'h00FF);
        @(negedge clk);
        sb_check(int'(out));

        // All pins PWM at 50%; first period after reset uses duty 0.
        set_en(16'hFFFF, 16'hFFFF);
        pwm_duty_cycle = 8'h80;
        sb_push("pwm_low_before_wrap", 0);
        @(negedge clk);
        sb_check(int'(out));
        wait_ps();
        run_measure("duty80_a", 16'hFFFF, 0, 8'h00, 1664, 1664, 1665);
        run_measure("duty80_b", 16'hFFFF, 0, 8'h00, 1664, 1664, 1665);

        // 0x00 then 0xFF, each taking effect at the following period start.
        pwm_duty_cycle = 8'h00;
        wait_ps();
        run_measure("duty00", 16'hFFFF, 1, 8'hFF, 0, PERIOD, 0);
        run_measure("dutyFF", 16'hFFFF, 0, 8'h00, PERIOD, 0, 0);

        // Mid-period write at pwm_cnt=40 is held off until the next period.
        pwm_duty_cycle = 8'h40;
        wait_ps();
        run_measure("duty40_hold", 16'hFFFF, 521, 8'hC0, 832, 2496, 833);
        run_measure("dutyC0", 16'hFFFF, 0, 8'h00, 2496, 832, 2497);

        // Output enables gate PWM; pin 0 alone, aligned to period start.
        pwm_duty_cycle = 8'h80;
        set_en(16'h0000, 16'hFFFF);
        wait_ps();
        run_measure("gated", 16'h0001, 0, 8'h00, 0, PERIOD, 0);
        set_en(16'h0001, 16'hFFFF);
        run_measure("pin0", 16'h0001, 0, 8'h00, 1664, 1664, 1665);

        // Asynchronous reset at pwm_cnt=100 while pins are high.
        set_en(16'hFFFF, 16'hFFFF);
        repeat (1301) @(negedge clk);
        sb_push("pre_reset_out", 16'hFFFF);
        sb_check(int'(out));
        @(posedge clk);
        #10 rst = 1'b1;
        #1;
        sb_push("async_reset_out", 0);
        sb_check(int'(out));
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n = 0;
        nonzero = 0;
        do begin
            @(negedge clk);
            n++;
            if (out != 16'h0000)
                nonzero++;
        end while (!period_start && n < PERIOD + 100);
        sb_push("post_reset_first_ps", PERIOD);
        sb_push("post_reset_pins_low", 0);
        sb_check(n);
        sb_check(nonzero);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
